// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-way select mux feeding a registered 2-entry valid/ready output buffer
module mux_n_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter int               ONEHOT      = 0,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             err0;
    logic             err1;
    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             push;
    logic             pop;
    logic             load0_cap;
    logic             load0_skid;
    logic             load1_cap;

    // Invalid selects resolve to DEFAULT_VAL with err set, so every select value is covered.
    generate
        if (ONEHOT != 0) begin : g_onehot
            logic [4:0] ones;

            always_comb begin
                ones     = '0;
                cap_data = DEFAULT_VAL;
                cap_err  = 1'b1;
                for (int k = 0; k < NUM_IN; k++) begin
                    ones = ones + 5'(sel[k]);
                end
                if (ones == 5'd1) begin
                    cap_err = 1'b0;
                    for (int k = 0; k < NUM_IN; k++) begin
                        if (sel[k]) begin
                            cap_data = in_data[k*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end else begin : g_binary
            always_comb begin
                cap_data = DEFAULT_VAL;
                cap_err  = 1'b1;
                for (int k = 0; k < NUM_IN; k++) begin
                    if (int'(sel) == k) begin
                        cap_data = in_data[k*WIDTH +: WIDTH];
                        cap_err  = 1'b0;
                    end
                end
            end
        end
    endgenerate

    // in_ready comes only from registered state and flush, so downstream ready never ripples upstream.
    assign in_ready  = (state != TWO) && !flush;
    assign out_valid = (state != EMPTY);
    assign out_data  = entry0;
    assign out_err   = err0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt  = state;
        load0_cap  = 1'b0;
        load0_skid = 1'b0;
        load1_cap  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        load0_cap = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load0_cap = 1'b1;
                    end else if (push) begin
                        state_nxt = TWO;
                        load1_cap = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt  = ONE;
                        load0_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Entries are only overwritten on load; pop and flush leave stale contents behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            err0   <= 1'b0;
            entry1 <= '0;
            err1   <= 1'b0;
        end else begin
            if (load0_cap) begin
                entry0 <= cap_data;
                err0   <= cap_err;
            end else if (load0_skid) begin
                entry0 <= entry1;
                err0   <= err1;
            end
            if (load1_cap) begin
                entry1 <= cap_data;
                err1   <= cap_err;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - self-checking bench for mux_n_pipe (binary, short binary and one-hot variants)
module tb_mux_n_pipe;

    logic        clk;
    logic        rst;
    logic [63:0] din;
    logic [1:0]  sel2;
    logic [3:0]  sel4;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        rdy_a, rdy_b, rdy_c;
    logic [15:0] dat_a, dat_b, dat_c;
    logic        err_a, err_b, err_c;
    logic        vld_a, vld_b, vld_c;

    int total = 0;
    int bad   = 0;

    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] qc[$];

    mux_n_pipe #(.WIDTH(16), .NUM_IN(4), .ONEHOT(0), .SEL_W(2), .DEFAULT_VAL(16'hBEEF)) dut_a (
        .clk(clk), .rst(rst), .in_data(din), .sel(sel2), .in_valid(in_valid), .in_ready(rdy_a),
        .flush(flush), .out_data(dat_a), .out_err(err_a), .out_valid(vld_a), .out_ready(out_ready));

    mux_n_pipe #(.WIDTH(16), .NUM_IN(3), .ONEHOT(0), .SEL_W(2), .DEFAULT_VAL(16'hDEAD)) dut_b (
        .clk(clk), .rst(rst), .in_data(din[47:0]), .sel(sel2), .in_valid(in_valid), .in_ready(rdy_b),
        .flush(flush), .out_data(dat_b), .out_err(err_b), .out_valid(vld_b), .out_ready(out_ready));

    mux_n_pipe #(.WIDTH(16), .NUM_IN(4), .ONEHOT(1), .SEL_W(4), .DEFAULT_VAL(16'hC0DE)) dut_c (
        .clk(clk), .rst(rst), .in_data(din), .sel(sel4), .in_valid(in_valid), .in_ready(rdy_c),
        .flush(flush), .out_data(dat_c), .out_err(err_c), .out_valid(vld_c), .out_ready(out_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_a(input logic [1:0] s, input logic [63:0] d);
        logic [63:0] sh;
        sh = d >> (16 * int'(s));
        return {1'b0, sh[15:0]};
    endfunction

    function automatic logic [16:0] ref_b(input logic [1:0] s, input logic [63:0] d);
        logic [63:0] sh;
        if (int'(s) >= 3) return {1'b1, 16'hDEAD};
        sh = d >> (16 * int'(s));
        return {1'b0, sh[15:0]};
    endfunction

    function automatic logic [16:0] ref_c(input logic [3:0] s, input logic [63:0] d);
        logic [63:0] sh;
        int idx;
        if ($countones(s) != 1) return {1'b1, 16'hC0DE};
        idx = 0;
        for (int k = 0; k < 4; k++) if (s[k]) idx = k;
        sh = d >> (16 * idx);
        return {1'b0, sh[15:0]};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".vld_a"}, 32'(vld_a), 32'(qa.size() != 0));
        chk({tag, ".vld_b"}, 32'(vld_b), 32'(qb.size() != 0));
        chk({tag, ".vld_c"}, 32'(vld_c), 32'(qc.size() != 0));
        if (qa.size() != 0) chk({tag, ".a"}, 32'({err_a, dat_a}), 32'(qa[0]));
        if (qb.size() != 0) chk({tag, ".b"}, 32'({err_b, dat_b}), 32'(qb[0]));
        if (qc.size() != 0) chk({tag, ".c"}, 32'({err_c, dat_c}), 32'(qc[0]));
    endtask

    // One clock: drive at negedge, check in_ready, advance the queue model at posedge, check outputs.
    task automatic step(input string tag, input logic iv, input logic ordy, input logic fl,
                        input logic [1:0] s2, input logic [3:0] s4, input logic [63:0] d);
        logic exp_rdy, do_push, do_pop;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        sel2      = s2;
        sel4      = s4;
        din       = d;
        #1;
        exp_rdy = (qa.size() < 2) && !fl;
        chk({tag, ".rdy_a"}, 32'(rdy_a), 32'(exp_rdy));
        chk({tag, ".rdy_b"}, 32'(rdy_b), 32'(exp_rdy));
        chk({tag, ".rdy_c"}, 32'(rdy_c), 32'(exp_rdy));
        do_push = iv && exp_rdy;
        do_pop  = ordy && (qa.size() != 0);
        @(posedge clk);
        if (fl) begin
            qa.delete(); qb.delete(); qc.delete();
        end else begin
            if (do_pop) begin
                void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
            end
            if (do_push) begin
                qa.push_back(ref_a(s2, d));
                qb.push_back(ref_b(s2, d));
                qc.push_back(ref_c(s4, d));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_outputs(tag);
    endtask

    typedef struct {
        logic [1:0]  s2;
        logic [3:0]  s4;
        logic [16:0] ea;
        logic [16:0] eb;
        logic [16:0] ec;
    } vec_t;

    localparam logic [63:0] FIXED = 64'h0044_0033_0022_0011;

    initial begin
        vec_t vecs[6];
        logic [63:0] rd;

        vecs[0] = '{2'd2, 4'b0100, {1'b0, 16'h0033}, {1'b0, 16'h0033}, {1'b0, 16'h0033}};
        vecs[1] = '{2'd3, 4'b0110, {1'b0, 16'h0044}, {1'b1, 16'hDEAD}, {1'b1, 16'hC0DE}};
        vecs[2] = '{2'd0, 4'b0000, {1'b0, 16'h0011}, {1'b0, 16'h0011}, {1'b1, 16'hC0DE}};
        vecs[3] = '{2'd1, 4'b1000, {1'b0, 16'h0022}, {1'b0, 16'h0022}, {1'b0, 16'h0044}};
        vecs[4] = '{2'd3, 4'b0001, {1'b0, 16'h0044}, {1'b1, 16'hDEAD}, {1'b0, 16'h0011}};
        vecs[5] = '{2'd1, 4'b1111, {1'b0, 16'h0022}, {1'b0, 16'h0022}, {1'b1, 16'hC0DE}};

        rst = 1'b1; din = '0; sel2 = '0; sel4 = '0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.vld", 32'({vld_a, vld_b, vld_c}), 32'd0);
        chk("rst.data", 32'({dat_a, dat_b}), 32'd0);
        chk("rst.err", 32'({err_a, err_b, err_c}), 32'd0);
        chk("rst.rdy", 32'({rdy_a, rdy_b, rdy_c}), 32'h7);
        rst = 1'b0;
        @(negedge clk);

        // Single-beat captures from an empty buffer, visible one cycle after accept.
        for (int i = 0; i < 6; i++) begin
            step("vec", 1'b1, 1'b1, 1'b0, vecs[i].s2, vecs[i].s4, FIXED);
            chk("vec.a", 32'({err_a, dat_a}), 32'(vecs[i].ea));
            chk("vec.b", 32'({err_b, dat_b}), 32'(vecs[i].eb));
            chk("vec.c", 32'({err_c, dat_c}), 32'(vecs[i].ec));
            step("vec.drain", 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);
        end

        // Stall: A then B fill the buffer; head holds A until out_ready.
        step("stall.a", 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 64'h0000_0000_0000_0AAA);
        step("stall.b", 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 64'h0000_0000_0000_0BBB);
        step("stall.full", 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 64'h0000_0000_0000_0CCC);
        chk("stall.hold", 32'(dat_a), 32'h0AAA);
        chk("stall.rdy", 32'(rdy_a), 32'd0);
        step("stall.pop1", 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);
        chk("stall.b_next", 32'(dat_a), 32'h0BBB);
        step("stall.pop2", 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);
        chk("stall.empty", 32'(vld_a), 32'd0);

        // Streaming: one beat per cycle, occupancy stays at one.
        for (int i = 0; i < 8; i++) begin
            step("stream", 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 64'(16'h0100 + 16'(i)));
            chk("stream.data", 32'(dat_a), 32'(16'h0100 + 16'(i)));
            chk("stream.vld", 32'(vld_a), 32'd1);
        end
        step("stream.drain", 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);

        // Flush with a full buffer and an offered beat.
        step("fl.a", 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, FIXED);
        step("fl.b", 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, FIXED);
        step("fl.go", 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, FIXED);
        chk("fl.vld", 32'({vld_a, vld_b, vld_c}), 32'd0);
        step("fl.after", 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);

        // Asynchronous reset with one entry buffered.
        step("ar.push", 1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, FIXED);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.vld", 32'({vld_a, vld_b, vld_c}), 32'd0);
        chk("ar.data", 32'(dat_c), 32'd0);
        qa.delete(); qb.delete(); qc.delete();
        @(negedge clk);
        rst = 1'b0;
        step("ar.after", 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, '0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] s4r;
            rd  = {$urandom, $urandom};
            s4r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            step("rand", 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0), 2'($urandom), s4r, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
